// File: rtl/rom_state.sv
// rom_state: sequence-playback controller.
// Reads a tag-list entry (start, end, last flag) from an external RAM at
// ram_counter, then walks a 10-bit ROM address from start to end and loops.
// Push-button rising edges step the tag-list pointer forward or backward.
module rom_state (
    input  logic        clock_n,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        pb_seq_up,
    input  logic        pb_seq_dn,
    output logic        load,
    output logic [9:0]  addr,
    output logic [6:0]  ram_counter,
    output logic        at_end_rst,
    output logic        addr_inc,
    output logic        ram_counter_inc,
    output logic        ram_counter_dec
);

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        LOAD   = 2'd2,
        IN_SEQ = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Entry fields captured in LOAD; start is kept so the loop can wrap.
    logic [9:0] start_addr;
    logic [9:0] end_addr;
    logic       last_flag;

    // Button samples: current and previous cycle, used for edge detection.
    // Buttons go through a register first so no path from the pins reaches
    // the address or pointer logic combinationally.
    logic up_now;
    logic up_prev;
    logic dn_now;
    logic dn_prev;

    logic up_edge;
    logic dn_edge;
    logic in_seq;
    logic at_end;
    logic up_act;
    logic dn_act;

    // Sequence id and the top nibble of the tag word are not used here.
    logic unused_bits;
    assign unused_bits = ^data_in[31:21];

    assign up_edge = up_now & ~up_prev;
    assign dn_edge = dn_now & ~dn_prev;
    assign in_seq  = (state == IN_SEQ);
    assign at_end  = (addr == end_addr);

    // Edges only count in IN_SEQ, and simultaneous up/down cancel out.
    // A down request at entry 0 is ignored so the current sequence keeps looping.
    assign up_act  = in_seq & up_edge & ~dn_edge;
    assign dn_act  = in_seq & dn_edge & ~up_edge & (ram_counter != 7'd0);

    // Sample both buttons every cycle for rising-edge detection.
    always_ff @(posedge clock_n) begin
        if (!reset) begin
            up_now  <= 1'b0;
            up_prev <= 1'b0;
            dn_now  <= 1'b0;
            dn_prev <= 1'b0;
        end else begin
            up_now  <= pb_seq_up;
            up_prev <= up_now;
            dn_now  <= pb_seq_dn;
            dn_prev <= dn_now;
        end
    end

    // State register.
    always_ff @(posedge clock_n) begin
        if (!reset) begin
            state <= FETCH1;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: two wait cycles cover the RAM read latency.
    always_comb begin
        state_next = state;
        case (state)
            FETCH1: state_next = FETCH2;
            FETCH2: state_next = LOAD;
            LOAD:   state_next = IN_SEQ;
            IN_SEQ: begin
                if (up_act || dn_act) begin
                    state_next = FETCH1;
                end
            end
            default: state_next = FETCH1;
        endcase
    end

    // Output decode from state and registered values only.
    always_comb begin
        load            = (state == LOAD);
        at_end_rst      = in_seq & at_end;
        addr_inc        = in_seq & ~at_end;
        ram_counter_inc = up_act;
        ram_counter_dec = dn_act;
    end

    // Address datapath and captured entry fields; addr holds while fetching.
    always_ff @(posedge clock_n) begin
        if (!reset) begin
            addr       <= 10'd0;
            start_addr <= 10'd0;
            end_addr   <= 10'd0;
            last_flag  <= 1'b0;
        end else begin
            if (state == LOAD) begin
                addr       <= data_in[20:11];
                start_addr <= data_in[20:11];
                end_addr   <= data_in[10:1];
                last_flag  <= data_in[0];
            end else if (addr_inc) begin
                addr <= addr + 10'd1;
            end else if (at_end_rst) begin
                addr <= start_addr;
            end
        end
    end

    // Tag-list pointer: wraps to 0 after the entry flagged as last.
    always_ff @(posedge clock_n) begin
        if (!reset) begin
            ram_counter <= 7'd0;
        end else if (up_act) begin
            ram_counter <= last_flag ? 7'd0 : ram_counter + 7'd1;
        end else if (dn_act) begin
            ram_counter <= ram_counter - 7'd1;
        end
    end

endmodule

// File: tb/tb_rom_state.sv
// tb_rom_state: directed self-checking bench for rom_state.
// Models the tag-list RAM with two cycles of read latency and checks
// loading, looping, pointer stepping, button edge handling and reset.
module tb_rom_state;

    logic        clock_n;
    logic        reset;
    logic [31:0] data_in;
    logic        pb_seq_up;
    logic        pb_seq_dn;
    logic        load;
    logic [9:0]  addr;
    logic [6:0]  ram_counter;
    logic        at_end_rst;
    logic        addr_inc;
    logic        ram_counter_inc;
    logic        ram_counter_dec;

    int checks = 0;
    int errors = 0;

    logic [31:0] tag_mem [0:127];
    logic [6:0]  ram_addr_q;
    logic [9:0]  seq_start [0:4];
    logic [9:0]  seq_end   [0:4];

    rom_state dut (
        .clock_n         (clock_n),
        .reset           (reset),
        .data_in         (data_in),
        .pb_seq_up       (pb_seq_up),
        .pb_seq_dn       (pb_seq_dn),
        .load            (load),
        .addr            (addr),
        .ram_counter     (ram_counter),
        .at_end_rst      (at_end_rst),
        .addr_inc        (addr_inc),
        .ram_counter_inc (ram_counter_inc),
        .ram_counter_dec (ram_counter_dec)
    );

    // Free-running clock.
    initial begin
        clock_n = 1'b0;
        forever #5 clock_n = ~clock_n;
    end

    // Tag-list RAM: address registered on one edge, data on the next.
    always @(posedge clock_n) begin
        ram_addr_q <= ram_counter;
        data_in    <= tag_mem[ram_addr_q];
    end

    // Safety net in case the run stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock_n);
        #1;
    endtask

    task automatic nav_up();
        pb_seq_up = 1'b1;
        step();
        pb_seq_up = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        int len;
        reset = 1'b0;
        repeat (3) step();
        checks++; if (addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0h expected 0", addr); end
        checks++; if (ram_counter !== 7'd0) begin errors++; $display("[TB] FAIL reset_ram_counter: got %0d expected 0", ram_counter); end
        checks++; if ({load, at_end_rst, addr_inc, ram_counter_inc, ram_counter_dec} !== 5'b0)
            begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 00000", {load, at_end_rst, addr_inc, ram_counter_inc, ram_counter_dec}); end
        reset = 1'b1;
        checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL first_load_c1: got %b expected 0", load); end
        step();
        checks++; if (load !== 1'b0) begin errors++; $display("[TB] FAIL first_load_c2: got %b expected 0", load); end
        step();
        checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL first_load_c3: got %b expected 1", load); end
        step();
        len = 6;
        for (int i = 0; i < len; i++) begin
            checks++; if (addr !== 10'(i)) begin errors++; $display("[TB] FAIL entry0_addr: got %0h expected %0h", addr, i); end
            checks++; if (at_end_rst !== (i == len - 1)) begin errors++; $display("[TB] FAIL entry0_at_end step %0d: got %b expected %b", i, at_end_rst, (i == len - 1)); end
            checks++; if (addr_inc !== (i != len - 1)) begin errors++; $display("[TB] FAIL entry0_addr_inc step %0d: got %b expected %b", i, addr_inc, (i != len - 1)); end
            step();
        end
        checks++; if (addr !== 10'd0) begin errors++; $display("[TB] FAIL entry0_wrap: got %0h expected 0", addr); end
    endtask

    task automatic test_seq_up();
        int len;
        for (int k = 1; k <= 4; k++) begin
            pb_seq_up = 1'b1;
            step();
            pb_seq_up = 1'b0;
            checks++; if (ram_counter_inc !== 1'b1) begin errors++; $display("[TB] FAIL up_strobe entry %0d: got %b expected 1", k, ram_counter_inc); end
            step();
            checks++; if (ram_counter !== 7'(k)) begin errors++; $display("[TB] FAIL up_counter: got %0d expected %0d", ram_counter, k); end
            checks++; if (ram_counter_inc !== 1'b0) begin errors++; $display("[TB] FAIL up_strobe_width entry %0d: got %b expected 0", k, ram_counter_inc); end
            step();
            step();
            checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL up_load entry %0d: got %b expected 1", k, load); end
            step();
            len = int'(seq_end[k]) - int'(seq_start[k]) + 1;
            for (int i = 0; i < len; i++) begin
                checks++; if (addr !== seq_start[k] + 10'(i)) begin errors++; $display("[TB] FAIL up_addr entry %0d: got %0h expected %0h", k, addr, seq_start[k] + 10'(i)); end
                checks++; if (at_end_rst !== (i == len - 1)) begin errors++; $display("[TB] FAIL up_at_end entry %0d step %0d: got %b expected %b", k, i, at_end_rst, (i == len - 1)); end
                step();
            end
            checks++; if (addr !== seq_start[k]) begin errors++; $display("[TB] FAIL up_wrap entry %0d: got %0h expected %0h", k, addr, seq_start[k]); end
        end
    endtask

    task automatic test_last_wrap();
        pb_seq_up = 1'b1;
        step();
        pb_seq_up = 1'b0;
        checks++; if (ram_counter_inc !== 1'b1) begin errors++; $display("[TB] FAIL last_strobe: got %b expected 1", ram_counter_inc); end
        step();
        checks++; if (ram_counter !== 7'd0) begin errors++; $display("[TB] FAIL last_wrap_counter: got %0d expected 0", ram_counter); end
        step();
        step();
        checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL last_load: got %b expected 1", load); end
        step();
        for (int i = 0; i < 6; i++) begin
            checks++; if (addr !== 10'(i)) begin errors++; $display("[TB] FAIL last_addr: got %0h expected %0h", addr, i); end
            step();
        end
        checks++; if (addr !== 10'd0) begin errors++; $display("[TB] FAIL last_loop_wrap: got %0h expected 0", addr); end
    endtask

    task automatic test_seq_dn();
        logic [9:0] exp_addr;
        repeat (4) nav_up();
        checks++; if (ram_counter !== 7'd4) begin errors++; $display("[TB] FAIL dn_setup_counter: got %0d expected 4", ram_counter); end
        for (int k = 4; k >= 1; k--) begin
            pb_seq_dn = 1'b1;
            step();
            pb_seq_dn = 1'b0;
            checks++; if ({ram_counter_dec, ram_counter_inc} !== 2'b10) begin errors++; $display("[TB] FAIL dn_strobe from %0d: got dec/inc %b expected 10", k, {ram_counter_dec, ram_counter_inc}); end
            step();
            checks++; if (ram_counter !== 7'(k - 1)) begin errors++; $display("[TB] FAIL dn_counter: got %0d expected %0d", ram_counter, k - 1); end
            step();
            step();
            checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL dn_load to %0d: got %b expected 1", k - 1, load); end
            step();
            checks++; if (addr !== seq_start[k-1]) begin errors++; $display("[TB] FAIL dn_start to %0d: got %0h expected %0h", k - 1, addr, seq_start[k-1]); end
        end
        pb_seq_dn = 1'b1;
        step();
        pb_seq_dn = 1'b0;
        exp_addr = 10'd1;
        checks++; if (ram_counter_dec !== 1'b0) begin errors++; $display("[TB] FAIL dn_at_zero_strobe: got %b expected 0", ram_counter_dec); end
        for (int i = 0; i < 12; i++) begin
            checks++; if (addr !== exp_addr || load !== 1'b0 || ram_counter !== 7'd0)
                begin errors++; $display("[TB] FAIL dn_at_zero_loop: got addr %0h load %b cnt %0d expected addr %0h load 0 cnt 0", addr, load, ram_counter, exp_addr); end
            exp_addr = (exp_addr == 10'd5) ? 10'd0 : exp_addr + 10'd1;
            step();
        end
    endtask

    task automatic test_simultaneous();
        pb_seq_up = 1'b1;
        pb_seq_dn = 1'b1;
        step();
        pb_seq_up = 1'b0;
        pb_seq_dn = 1'b0;
        checks++; if ({ram_counter_inc, ram_counter_dec} !== 2'b00) begin errors++; $display("[TB] FAIL both_strobes: got %b expected 00", {ram_counter_inc, ram_counter_dec}); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (load !== 1'b0 || ram_counter !== 7'd0 || addr > 10'd5)
                begin errors++; $display("[TB] FAIL both_loop: got load %b cnt %0d addr %0h expected load 0 cnt 0 addr<=5", load, ram_counter, addr); end
            step();
        end
    endtask

    task automatic test_held_up();
        int inc_count;
        inc_count = 0;
        pb_seq_up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) pb_seq_up = 1'b0;
            step();
            if (ram_counter_inc === 1'b1) inc_count++;
        end
        checks++; if (inc_count != 1) begin errors++; $display("[TB] FAIL held_up_count: got %0d expected 1", inc_count); end
        checks++; if (ram_counter !== 7'd1) begin errors++; $display("[TB] FAIL held_up_counter: got %0d expected 1", ram_counter); end
    endtask

    task automatic test_reset_mid();
        nav_up();
        checks++; if (ram_counter !== 7'd2) begin errors++; $display("[TB] FAIL mid_setup_counter: got %0d expected 2", ram_counter); end
        repeat (5) step();
        reset = 1'b0;
        step();
        checks++; if (addr !== 10'd0 || ram_counter !== 7'd0 || load !== 1'b0)
            begin errors++; $display("[TB] FAIL mid_reset: got addr %0h cnt %0d load %b expected 0 0 0", addr, ram_counter, load); end
        reset = 1'b1;
        step();
        step();
        checks++; if (load !== 1'b1) begin errors++; $display("[TB] FAIL mid_reload: got %b expected 1", load); end
        step();
        for (int i = 0; i < 6; i++) begin
            checks++; if (addr !== 10'(i) || at_end_rst !== (i == 5))
                begin errors++; $display("[TB] FAIL mid_replay: got addr %0h end %b expected %0h %b", addr, at_end_rst, i, (i == 5)); end
            step();
        end
        checks++; if (addr !== 10'd0) begin errors++; $display("[TB] FAIL mid_replay_wrap: got %0h expected 0", addr); end
    endtask

    // Fill the tag list, then run the scenarios in order.
    initial begin
        seq_start[0] = 10'h000; seq_end[0] = 10'h005;
        seq_start[1] = 10'h006; seq_end[1] = 10'h00C;
        seq_start[2] = 10'h00D; seq_end[2] = 10'h015;
        seq_start[3] = 10'h016; seq_end[3] = 10'h02A;
        seq_start[4] = 10'h02B; seq_end[4] = 10'h03F;
        for (int i = 0; i < 128; i++) tag_mem[i] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tag_mem[i] = {4'h0, 7'(i + 1), seq_start[i], seq_end[i], (i == 4)};
        end
        reset     = 1'b0;
        pb_seq_up = 1'b0;
        pb_seq_dn = 1'b0;

        test_reset();
        test_seq_up();
        test_last_wrap();
        test_seq_dn();
        test_simultaneous();
        test_held_up();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
